// File: rtl/adder_axi_master.sv
// adder_axi_master: AXI4-Lite master that runs one adder-slave transaction
// per command: write A, write B, read sum, read overflow flag. The result
// is returned on a valid/ready result port.
//
// Optional feature macro: M1_AXI_TIMEOUT_EN
//   When defined, every bus phase is bounded by TIMEOUT_CYCLES. A phase that
//   hits the limit ends the command with res_err=1 and a zeroed result.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// WR_A   | writing operand A to ADDR_A (AW, W, B tracked independently)
// WR_B   | writing operand B to ADDR_B
// RD_SUM | reading ADDR_SUM into res_sum
// RD_OVF | reading ADDR_OVF, bit 0 into res_overflow
// RESP   | res_valid high until res_ready
module adder_axi_master #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_A         = 'h0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_B         = 'h4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SUM       = 'h8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_OVF       = 'hC,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_sum,
    output logic                    res_overflow,
    output logic                    res_err,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic                    m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic                    m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_A   = 3'd1;
    localparam logic [2:0] WR_B   = 3'd2;
    localparam logic [2:0] RD_SUM = 3'd3;
    localparam logic [2:0] RD_OVF = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  entering;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  aw_done, w_done, b_done, ar_done;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  in_wr, in_rd;
    logic                  wr_done, rd_done;
    logic                  tmo_hit;

    // Responses are not checked; the timeout limit is unused in the default build.
    logic unused_inputs;
    assign unused_inputs = ^{m1_axi_bresp, m1_axi_rresp, (TIMEOUT_CYCLES == 0)};

    assign aw_hs = m1_axi_awvalid && m1_axi_awready;
    assign w_hs  = m1_axi_wvalid  && m1_axi_wready;
    assign b_hs  = m1_axi_bvalid  && m1_axi_bready;
    assign ar_hs = m1_axi_arvalid && m1_axi_arready;
    // ar_done is registered, so an R beat only counts in a cycle after the AR handshake.
    assign r_hs  = m1_axi_rvalid  && m1_axi_rready && ar_done;

    assign in_wr   = (state == WR_A) || (state == WR_B);
    assign in_rd   = (state == RD_SUM) || (state == RD_OVF);
    assign wr_done = in_wr && (aw_done || aw_hs) && (w_done || w_hs) && (b_done || b_hs);
    assign rd_done = in_rd && r_hs;

    // Next-state selection; a timeout abandons the current phase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_ready) state_nxt = WR_A;
            WR_A:    if (wr_done) state_nxt = WR_B;   else if (tmo_hit) state_nxt = RESP;
            WR_B:    if (wr_done) state_nxt = RD_SUM; else if (tmo_hit) state_nxt = RESP;
            RD_SUM:  if (rd_done) state_nxt = RD_OVF; else if (tmo_hit) state_nxt = RESP;
            RD_OVF:  if (rd_done || tmo_hit) state_nxt = RESP;
            RESP:    if (res_valid && res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign entering = (state_nxt != state);

    // State register, command acceptance and operand B capture.
    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            op_b      <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            if (state == IDLE && cmd_valid && cmd_ready) begin
                op_b <= cmd_b;
            end
        end
    end

    // Write address/data/response channels; each completion is remembered separately.
    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            m1_axi_awaddr  <= '0;
            m1_axi_awvalid <= 1'b0;
            m1_axi_wdata   <= '0;
            m1_axi_wstrb   <= '0;
            m1_axi_wvalid  <= 1'b0;
            m1_axi_bready  <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            b_done         <= 1'b0;
        end else if (entering) begin
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            b_done         <= 1'b0;
            m1_axi_awvalid <= (state_nxt == WR_A) || (state_nxt == WR_B);
            m1_axi_wvalid  <= (state_nxt == WR_A) || (state_nxt == WR_B);
            m1_axi_bready  <= (state_nxt == WR_A) || (state_nxt == WR_B);
            if (state_nxt == WR_A) begin
                // Operand A goes straight from the command port; it is not needed later.
                m1_axi_awaddr <= ADDR_A;
                m1_axi_wdata  <= cmd_a;
                m1_axi_wstrb  <= '1;
            end else if (state_nxt == WR_B) begin
                m1_axi_awaddr <= ADDR_B;
                m1_axi_wdata  <= op_b;
                m1_axi_wstrb  <= '1;
            end
        end else begin
            if (aw_hs) begin
                m1_axi_awvalid <= 1'b0;
                aw_done        <= 1'b1;
            end
            if (w_hs) begin
                m1_axi_wvalid <= 1'b0;
                w_done        <= 1'b1;
            end
            if (b_hs) begin
                b_done <= 1'b1;
            end
        end
    end

    // Read address/data channels.
    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            m1_axi_araddr  <= '0;
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b0;
            ar_done        <= 1'b0;
        end else if (entering) begin
            ar_done        <= 1'b0;
            m1_axi_arvalid <= (state_nxt == RD_SUM) || (state_nxt == RD_OVF);
            m1_axi_rready  <= (state_nxt == RD_SUM) || (state_nxt == RD_OVF);
            if (state_nxt == RD_SUM) begin
                m1_axi_araddr <= ADDR_SUM;
            end else if (state_nxt == RD_OVF) begin
                m1_axi_araddr <= ADDR_OVF;
            end
        end else if (ar_hs) begin
            m1_axi_arvalid <= 1'b0;
            ar_done        <= 1'b1;
        end
    end

    // Result capture and result handshake.
    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_overflow <= 1'b0;
        end else begin
            if (state == RESP && state_nxt == IDLE) begin
                res_valid <= 1'b0;
            end else if (state != RESP && state_nxt == RESP) begin
                res_valid <= 1'b1;
            end
            if (tmo_hit) begin
                res_sum      <= '0;
                res_overflow <= 1'b0;
            end else if (state == RD_SUM && rd_done) begin
                res_sum <= m1_axi_rdata;
            end else if (state == RD_OVF && rd_done) begin
                res_overflow <= m1_axi_rdata[0];
            end
        end
    end

`ifdef M1_AXI_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (in_wr || in_rd) && !wr_done && !rd_done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Per-phase cycle counter and sticky error flag for the current command.
    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            tmo_cnt <= '0;
            res_err <= 1'b0;
        end else begin
            if (entering) begin
                tmo_cnt <= '0;
            end else if (in_wr || in_rd) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (tmo_hit) begin
                res_err <= 1'b1;
            end else if (state == RESP && state_nxt == IDLE) begin
                res_err <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign res_err = 1'b0;
`endif

endmodule
